// File: rtl/btn_conditioner_pkg.sv
// Shared encodings for the push-button front end: debounce FSM states and
// channel indices within the btn_* vectors.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

  // Bit order of every btn_* vector: {handClean,down,right,middle,left,up}
  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_MID   = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_DOWN  = 4;
  localparam int BTN_CLEAN = 5;

  // Cycles in a millisecond-based interval for a given clock rate
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, 4-state debounce FSM with a stability
// counter, and registered level / press pulse / release pulse.
// rise_acc/fall_acc are the combinational acceptance strobes; they line up with
// the edge that loads pulse/rel, so the parent can register companion outputs
// (e.g. mid_short) on the very same edge.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rel,
  output logic rise_acc,
  output logic fall_acc
);

  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

  logic          meta;
  logic          sync;
  db_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // Two-flop synchroniser; only sync feeds the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Next-state: a level change must hold for DB_CYC cycles of sync to be accepted
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_acc = 1'b0;
    fall_acc = 1'b0;
    case (state)
      S_LOW: begin
        if (sync) begin
          state_nx = S_RISE;
          cnt_nx   = CW'(1);
        end
      end
      S_RISE: begin
        if (!sync) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
          rise_acc = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_nx = S_FALL;
          cnt_nx   = CW'(1);
        end
      end
      S_FALL: begin
        // a bounce back to 1 keeps the press alive
        if (sync) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
          fall_acc = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = S_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pulse <= rise_acc;
      rel   <= fall_acc;
      if (rise_acc)      level <= 1'b1;
      else if (fall_acc) level <= 1'b0;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN debounced channels plus the middle-button
// short-press / long-hold classifier.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 3000,
  parameter int N_BTN         = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release,
  output logic             mid_short,
  output logic             long_press,
  output logic             mid_held
);

  localparam int DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LP_CYC = ms_to_cyc(CLK_HZ, LONG_PRESS_MS);
  localparam int LPW    = $clog2(LP_CYC + 1);
  localparam logic [LPW-1:0] LP_LAST = LPW'(LP_CYC - 1);

  logic [N_BTN-1:0] rise_acc;
  logic [N_BTN-1:0] fall_acc;
  logic [LPW-1:0]   lp_cnt;
  logic             unused_acc;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(.DB_CYC(DB_CYC)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[i]),
      .level    (btn_level[i]),
      .pulse    (btn_pulse[i]),
      .rel      (btn_release[i]),
      .rise_acc (rise_acc[i]),
      .fall_acc (fall_acc[i])
    );
  end

  // Only the middle channel's strobes drive the hold classifier
  assign unused_acc = ^{rise_acc, fall_acc};

  // Middle-button hold timer: fires long_press once at LP_CYC, then saturates.
  // Release (same edge as btn_release) classifies the press as short if the
  // hold never reached long_press; mid_held doubles as the "already fired" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
      mid_held   <= 1'b0;
      mid_short  <= 1'b0;
    end else begin
      long_press <= 1'b0;
      mid_short  <= 1'b0;
      if (fall_acc[BTN_MID]) begin
        lp_cnt    <= '0;
        mid_held  <= 1'b0;
        mid_short <= ~mid_held;
      end else if (rise_acc[BTN_MID]) begin
        lp_cnt <= '0;
      end else if (btn_level[BTN_MID]) begin
        if (lp_cnt == LP_LAST) begin
          if (!mid_held) begin
            long_press <= 1'b1;
            mid_held   <= 1'b1;
          end
        end else begin
          lp_cnt <= lp_cnt + LPW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: each test pushes the events it expects
// (cycle, pulse/release masks, mid_short, long_press); a negedge monitor pops
// and compares every cycle on which any event output is non-zero.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [5:0] btn_raw;
  logic [5:0] btn_level, btn_pulse, btn_release;
  logic       mid_short, long_press, mid_held;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int         cyc;
    logic [5:0] pulse;
    logic [5:0] rel;
    logic       ms;
    logic       lp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  btn_conditioner #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .N_BTN(6)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release),
    .mid_short(mid_short), .long_press(long_press), .mid_held(mid_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor / scoreboard comparator
  always @(negedge clk) begin
    if (btn_pulse != 6'h0 || btn_release != 6'h0 || mid_short || long_press) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d pulse=%h rel=%h ms=%b lp=%b required=no event",
                 cyc, btn_pulse, btn_release, mid_short, long_press);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc !== cyc || mon_e.pulse !== btn_pulse || mon_e.rel !== btn_release ||
            mon_e.ms !== mid_short || mon_e.lp !== long_press) begin
          miscompares++;
          $display("FAIL event got cyc=%0d pulse=%h rel=%h ms=%b lp=%b required cyc=%0d pulse=%h rel=%h ms=%b lp=%b",
                   cyc, btn_pulse, btn_release, mid_short, long_press,
                   mon_e.cyc, mon_e.pulse, mon_e.rel, mon_e.ms, mon_e.lp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input int c, input logic [5:0] p, input logic [5:0] r,
                      input logic ms, input logic lp);
    exp_t e;
    e.cyc = c; e.pulse = p; e.rel = r; e.ms = ms; e.lp = lp;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for all expected events to be consumed
  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing pending=%0d next_cyc=%0d required=0 pending", name,
               exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    int d;
    rst = 1'b0; btn_raw = 6'h3F;
    step(5);
    vectors++;
    if ({btn_level, btn_pulse, btn_release, mid_short, long_press, mid_held} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got lvl=%h pul=%h rel=%h ms=%b lp=%b held=%b required all 0",
               btn_level, btn_pulse, btn_release, mid_short, long_press, mid_held);
    end
    rst = 1'b1; d = cyc;
    push(d + 6, 6'h3F, 6'h00, 1'b0, 1'b0);
    drain("reset_pulse");
    step(1);
    vectors++;
    if (btn_level !== 6'h3F) begin
      miscompares++;
      $display("FAIL reset_level got %h required 3f", btn_level);
    end
    btn_raw = 6'h00; d = cyc;
    push(d + 6, 6'h00, 6'h3F, 1'b1, 1'b0);
    drain("reset_release");
    step(10);
  endtask

  task automatic test_glitch;
    int d;
    btn_raw = 6'h01;
    step(3);
    btn_raw = 6'h00;
    step(10);
    vectors++;
    if (btn_level[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_level got %b required 0", btn_level[0]);
    end
    btn_raw = 6'h01; d = cyc;
    push(d + 6, 6'h01, 6'h00, 1'b0, 1'b0);
    step(10);
    vectors++;
    if (btn_level[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_hold_level got %b required 1", btn_level[0]);
    end
    btn_raw = 6'h00;
    push(d + 16, 6'h00, 6'h01, 1'b0, 1'b0);
    drain("glitch");
    step(8);
  endtask

  task automatic test_short_press;
    int d;
    btn_raw = 6'h04; d = cyc;
    push(d + 6, 6'h04, 6'h00, 1'b0, 1'b0);
    step(10);
    btn_raw = 6'h00;
    push(d + 16, 6'h00, 6'h04, 1'b1, 1'b0);
    drain("short");
    vectors++;
    if (mid_held !== 1'b0) begin
      miscompares++;
      $display("FAIL short_held got %b required 0", mid_held);
    end
    step(8);
  endtask

  task automatic test_long_press;
    int d;
    btn_raw = 6'h04; d = cyc;
    push(d + 6, 6'h04, 6'h00, 1'b0, 1'b0);
    push(d + 26, 6'h00, 6'h00, 1'b0, 1'b1);
    step(30);
    vectors++;
    if (mid_held !== 1'b1) begin
      miscompares++;
      $display("FAIL long_held got %b required 1", mid_held);
    end
    step(10);
    btn_raw = 6'h00;
    push(d + 46, 6'h00, 6'h04, 1'b0, 1'b0);
    drain("long");
    vectors++;
    if (mid_held !== 1'b0) begin
      miscompares++;
      $display("FAIL long_held_after_release got %b required 0", mid_held);
    end
    step(8);
  endtask

  task automatic test_reset_mid_hold;
    int d, r;
    btn_raw = 6'h04; d = cyc;
    push(d + 6, 6'h04, 6'h00, 1'b0, 1'b0);
    step(18);
    rst = 1'b0;
    step(1);
    vectors++;
    if ({mid_held, long_press, btn_level[2]} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_outputs got held=%b lp=%b lvl=%b required 000",
               mid_held, long_press, btn_level[2]);
    end
    step(1);
    rst = 1'b1; r = cyc;
    push(r + 6, 6'h04, 6'h00, 1'b0, 1'b0);
    push(r + 26, 6'h00, 6'h00, 1'b0, 1'b1);
    step(30);
    vectors++;
    if (mid_held !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_held got %b required 1", mid_held);
    end
    btn_raw = 6'h00;
    push(r + 36, 6'h00, 6'h04, 1'b0, 1'b0);
    drain("rstmid");
    step(8);
  endtask

  task automatic test_fall_bounce;
    int d;
    btn_raw = 6'h04; d = cyc;
    push(d + 6, 6'h04, 6'h00, 1'b0, 1'b0);
    step(10);
    btn_raw = 6'h00;
    step(2);
    btn_raw = 6'h04;
    step(10);
    vectors++;
    if (btn_level[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_level got %b required 1", btn_level[2]);
    end
    btn_raw = 6'h00;
    // the hold keeps counting through the bounce, so long_press still lands at +20
    push(d + 26, 6'h00, 6'h00, 1'b0, 1'b1);
    push(d + 28, 6'h00, 6'h04, 1'b0, 1'b0);
    drain("bounce");
    step(8);
  endtask

  task automatic test_concurrent;
    int d;
    btn_raw = 6'h0A; d = cyc;
    push(d + 6, 6'h0A, 6'h00, 1'b0, 1'b0);
    step(8);
    btn_raw = 6'h00;
    push(d + 14, 6'h00, 6'h0A, 1'b0, 1'b0);
    drain("concurrent");
    step(8);
  endtask

  initial begin
    rst = 1'b0;
    btn_raw = 6'h00;
    test_reset;
    test_glitch;
    test_short_press;
    test_long_press;
    test_reset_mid_hold;
    test_fall_bounce;
    test_concurrent;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
